instr_fetch_unit: RTL and testbench

//  Fetch stage of the Simple_RISC pipeline and consumer of the execute-stage branch outputs.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the Simple_RISC fetch stage.
// Entry layout, FSM states and PC helpers.
package fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HALT
  } fetch_state_t;

  function automatic logic [PC_W-1:0] alignPc(
    input logic [PC_W-1:0] pc
  );
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush.
// Holds fetched entries and in-flight request tags.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      count <= count + CNT_W'(doPush)
                     - CNT_W'(doPop);
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Simple_RISC fetch stage: PC, imem requests,
// instruction buffer and branch redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = 4,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         isBranchTaken,
  input  logic [fetch_pkg::PC_W-1:0]   branchPC,
  input  logic                         fetchHalt,
  output logic                         imemReqValid,
  input  logic                         imemReqReady,
  output logic [fetch_pkg::PC_W-1:0]   imemReqAddr,
  input  logic                         imemRspValid,
  input  logic [fetch_pkg::INST_W-1:0] imemRspData,
  output logic                         instValid,
  input  logic                         instReady,
  output logic [fetch_pkg::INST_W-1:0] inst,
  output logic [fetch_pkg::PC_W-1:0]   instPC
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t    state;
  logic [PC_W-1:0] fetchPC;
  logic [PC_W-1:0] tagPC;
  logic [CNT_W-1:0] stale;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] outNext;
  logic            hasCredit;
  logic            reqFire;
  logic            rspFire;
  logic            bufPush;
  logic            bufPop;
  logic            bufEmpty;
  logic            bufFull;
  logic            tagEmpty;
  logic            tagFull;
  fetch_entry_t    rspEntry;
  fetch_entry_t    headEntry;

  assign hasCredit =
    ({1'b0, occupancy} + {1'b0, outstanding})
      < (CNT_W + 1)'(BUF_DEPTH);

  assign imemReqValid = (state == S_FETCH)
                     && hasCredit && !tagFull;
  assign imemReqAddr  = fetchPC;
  assign reqFire      = imemReqValid && imemReqReady;

  // a response with nothing in flight is a leftover
  // from before reset and is ignored
  assign rspFire = imemRspValid && !tagEmpty;
  assign bufPop  = instValid && instReady
                && !isBranchTaken;
  assign bufPush = rspFire && (stale == '0)
                && (!bufFull || bufPop);

  assign outNext = outstanding + CNT_W'(reqFire)
                 - CNT_W'(rspFire);

  assign rspEntry = '{pc: tagPC, inst: imemRspData};

  assign instValid = !bufEmpty;
  assign inst      = bufEmpty ? '0 : headEntry.inst;
  assign instPC    = bufEmpty ? '0 : headEntry.pc;

  fetch_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (isBranchTaken),
    .push    (bufPush),
    .pushData(rspEntry),
    .pop     (bufPop),
    .popData (headEntry),
    .empty   (bufEmpty),
    .full    (bufFull),
    .count   (occupancy)
  );

  // tag count doubles as the outstanding counter
  fetch_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(PC_W)
  ) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (1'b0),
    .push    (reqFire),
    .pushData(fetchPC),
    .pop     (rspFire),
    .popData (tagPC),
    .empty   (tagEmpty),
    .full    (tagFull),
    .count   (outstanding)
  );

  // FSM, PC advance/redirect and stale tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_BOOT;
      fetchPC <= RESET_PC;
      stale   <= '0;
    end else begin
      unique case (state)
        S_BOOT:
          state <= S_FETCH;
        S_FETCH:
          if (fetchHalt && !isBranchTaken)
            state <= S_HALT;
        S_HALT:
          if (!fetchHalt || isBranchTaken)
            state <= S_FETCH;
        default:
          state <= S_BOOT;
      endcase

      if (isBranchTaken)
        fetchPC <= alignPc(branchPC);
      else if (reqFire)
        fetchPC <= fetchPC + PC_W'(PC_STEP);

      if (isBranchTaken)
        stale <= outNext;
      else if (rspFire && (stale != '0))
        stale <= stale - 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model plus
// scoreboard of expected instruction stream.
module tb_instr_fetch_unit;

  localparam int BIG = 1000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        isBranchTaken;
  logic [31:0] branchPC;
  logic        fetchHalt;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        instValid;
  logic        instReady;
  logic [31:0] inst;
  logic [31:0] instPC;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
    int          epoch;
    int          due;
  } memReq_t;

  memReq_t     pend[$];
  logic [31:0] expq[$];
  memReq_t     cur;
  logic [31:0] nextAddr = 32'h0;
  int nChecks   = 0;
  int nFails    = 0;
  int epoch     = 0;
  int cycle     = 0;
  int memLat    = 1;
  int rspBudget = BIG;
  int popCount  = 0;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .isBranchTaken(isBranchTaken),
    .branchPC     (branchPC),
    .fetchHalt    (fetchHalt),
    .imemReqValid (imemReqValid),
    .imemReqReady (imemReqReady),
    .imemReqAddr  (imemReqAddr),
    .imemRspValid (imemRspValid),
    .imemRspData  (imemRspData),
    .instValid    (instValid),
    .instReady    (instReady),
    .inst         (inst),
    .instPC       (instPC)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(
    input logic [31:0] a
  );
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkEq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // in-order memory: answers each request after memLat
  always @(posedge clk) begin
    #1;
    cycle++;
    imemRspValid = 1'b0;
    imemRspData  = 32'h0;
    if (pend.size() != 0 && pend[0].due <= cycle
        && rspBudget > 0) begin
      cur = pend.pop_front();
      rspBudget--;
      imemRspValid = 1'b1;
      imemRspData  = memData(cur.addr);
    end
  end

  // scoreboard: sample between edges what the next
  // edge will act on
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      epoch++;
      nextAddr = 32'h0;
    end else begin
      if (instValid && instReady && !isBranchTaken) begin
        popCount++;
        checkEq("sb_nonempty",
                32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          logic [31:0] e;
          e = expq.pop_front();
          checkEq("instPC", instPC, e);
          checkEq("inst", inst, memData(e));
        end
      end
      if (imemRspValid && cur.epoch == epoch
          && !isBranchTaken)
        expq.push_back(cur.exp);
      if (imemReqValid && imemReqReady) begin
        checkEq("reqAddr", imemReqAddr, nextAddr);
        pend.push_back('{imemReqAddr, nextAddr,
                         epoch, cycle + memLat});
        nextAddr = nextAddr + 32'd4;
      end
      if (isBranchTaken) begin
        expq.delete();
        epoch++;
        nextAddr = branchPC & ~32'd3;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkEq({tag, "_reqv"}, 32'(imemReqValid), 0);
    checkEq({tag, "_addr"}, imemReqAddr, 0);
    checkEq({tag, "_iv"}, 32'(instValid), 0);
    checkEq({tag, "_inst"}, inst, 0);
    checkEq({tag, "_ipc"}, instPC, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step(2);
    checkIdle("rst");
    rst_n = 1'b1;
  endtask

  task automatic waitInst(input string tag,
                          input int limit);
    for (int i = 0; i < limit && !instValid; i++)
      step(1);
    checkEq({tag, "_wait"}, 32'(instValid), 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    isBranchTaken = 1'b0;
    branchPC      = 32'h0;
    fetchHalt     = 1'b0;
    imemReqReady  = 1'b1;
    instReady     = 1'b1;

    // sequential stream
    doReset();
    popCount = 0;
    step(30);
    checkEq("t1_pops", 32'(popCount >= 12), 1);

    // back-pressure fills the buffer
    instReady = 1'b0;
    doReset();
    step(10);
    checkEq("t2_reqv", 32'(imemReqValid), 0);
    checkEq("t2_iv", 32'(instValid), 1);
    checkEq("t2_pc", instPC, 32'h0);
    checkEq("t2_inst", inst, memData(32'h0));
    instReady = 1'b1;
    step(10);

    // redirect with two requests in flight
    memLat = 6;
    doReset();
    step(4);
    checkEq("t3_reqv", 32'(imemReqValid), 0);
    checkEq("t3_iv", 32'(instValid), 0);
    isBranchTaken = 1'b1;
    branchPC      = 32'h0000_0103;
    step(1);
    isBranchTaken = 1'b0;
    memLat        = 1;
    checkEq("t3_addr", imemReqAddr, 32'h100);
    checkEq("t3_iv0", 32'(instValid), 0);
    waitInst("t3", 60);
    checkEq("t3_pc", instPC, 32'h100);
    step(6);

    // redirect coinciding with handshake and response
    rspBudget = 0;
    doReset();
    step(5);
    imemReqReady = 1'b0;
    rspBudget    = 1;
    step(4);
    checkEq("t4_reqv", 32'(imemReqValid), 1);
    checkEq("t4_addr", imemReqAddr, 32'h8);
    checkEq("t4_iv", 32'(instValid), 0);
    rspBudget = 1;
    step(1);
    checkEq("t4_rsp", 32'(imemRspValid), 1);
    imemReqReady  = 1'b1;
    isBranchTaken = 1'b1;
    branchPC      = 32'h0000_0200;
    step(1);
    isBranchTaken = 1'b0;
    rspBudget     = BIG;
    checkEq("t4_reqv2", 32'(imemReqValid), 1);
    checkEq("t4_addr2", imemReqAddr, 32'h200);
    checkEq("t4_iv2", 32'(instValid), 0);
    waitInst("t4", 40);
    checkEq("t4_pc", instPC, 32'h200);
    step(6);

    // halt with one request outstanding
    fetchHalt = 1'b1;
    instReady = 1'b0;
    doReset();
    step(6);
    checkEq("t5_reqv", 32'(imemReqValid), 0);
    checkEq("t5_iv", 32'(instValid), 1);
    checkEq("t5_pc", instPC, 32'h0);
    fetchHalt     = 1'b0;
    instReady     = 1'b1;
    isBranchTaken = 1'b1;
    branchPC      = 32'h0000_0300;
    step(1);
    isBranchTaken = 1'b0;
    checkEq("t5_reqv2", 32'(imemReqValid), 1);
    checkEq("t5_addr", imemReqAddr, 32'h300);
    checkEq("t5_iv2", 32'(instValid), 0);
    waitInst("t5", 40);
    checkEq("t5_pc2", instPC, 32'h300);
    step(4);

    // PC wrap, then reset with requests in flight
    doReset();
    step(3);
    isBranchTaken = 1'b1;
    branchPC      = 32'hFFFF_FFFE;
    step(1);
    isBranchTaken = 1'b0;
    for (int i = 0; i < 40 &&
         !(instValid && instPC == 32'hFFFF_FFFC); i++)
      step(1);
    checkEq("t6_top", instPC, 32'hFFFF_FFFC);
    step(1);
    waitInst("t6w", 20);
    checkEq("t6_wrap", instPC, 32'h0);
    memLat = 4;
    step(3);
    rst_n = 1'b0;
    step(1);
    checkIdle("t6_rst");
    rst_n        = 1'b1;
    imemReqReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checkEq("t6_iv", 32'(instValid), 0);
      checkEq("t6_ipc", instPC, 0);
      checkEq("t6_inst", inst, 0);
    end
    checkEq("t6_drained", 32'(pend.size()), 0);
    imemReqReady = 1'b1;
    waitInst("t6r", 40);
    checkEq("t6_pc", instPC, 32'h0);
    checkEq("t6_data", inst, memData(32'h0));
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
